// File: rtl/fir_stream_pkg.sv
// Shared types for the FIR output stream and its DAC sink.
package fir_stream_pkg;
   localparam int SAMPLE_W = 16;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {IDLE, RUN, STOP} dac_state_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a registered occupancy counter.
// Pointers wrap naturally because DEPTH is a power of two.
module sample_fifo
   import fir_stream_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  sample_t                  din,
   output sample_t                  dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   sample_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // storage array, written on accepted pushes only
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // pointers and occupancy; push+pop together leaves level unchanged
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/fir_dac_tx.sv
// FIR output sink: buffers samples and serialises them MSB-first onto a
// DSP-mode DAC link (sclk / fs / sdata) divided down from clk.
module fir_dac_tx
   import fir_stream_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 2,
   parameter int FRAME_BITS = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          in_valid,
   input  sample_t                       in_sample,
   output logic                          in_ready,
   output logic                          sclk,
   output logic                          fs,
   output logic                          sdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   underrun_cnt
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SW = $clog2(FRAME_BITS);
   localparam logic [SW-1:0] LAST_SLOT = SW'(FRAME_BITS-1);

   dac_state_t  state, state_nxt;
   logic [DW-1:0] div_cnt;
   logic [SW-1:0] slot;
   sample_t     shreg;
   sample_t     fifo_dout;
   logic        fifo_full, fifo_empty;
   logic        tick, shift_ev, wrap, halt, load, pop;

   // sclk toggles at divider terminal count; its falling edge is the shift event
   assign tick     = (state != IDLE) && (div_cnt == DW'(CLK_DIV-1));
   assign shift_ev = tick && sclk;
   assign wrap     = shift_ev && (slot == LAST_SLOT);
   // a stopping frame ends at the wrap instead of loading, unless en came back
   assign halt     = wrap && (state == STOP) && !en;
   assign load     = wrap && !halt;
   // pop decision uses pre-cycle occupancy, so a same-cycle push is not seen
   assign pop      = load && !fifo_empty;
   assign in_ready = !fifo_full;

   sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && in_ready),
      .pop   (pop),
      .din   (in_sample),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // next-state: RUN/STOP share timing, STOP only differs at the frame wrap
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = STOP;
         STOP:    if (halt) state_nxt = IDLE;
                  else if (en) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // divider, slot counter, shifter and link outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt      <= '0;
         sclk         <= 1'b0;
         slot         <= LAST_SLOT;
         shreg        <= '0;
         fs           <= 1'b0;
         sdata        <= 1'b0;
         underrun_cnt <= '0;
      end else if (state == IDLE) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
         slot    <= LAST_SLOT;
         shreg   <= '0;
         fs      <= 1'b0;
         sdata   <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) sclk <= ~sclk;
         if (halt) begin
            slot  <= LAST_SLOT;
            shreg <= '0;
            fs    <= 1'b0;
            sdata <= 1'b0;
         end else if (load) begin
            slot <= '0;
            fs   <= 1'b1;
            if (!fifo_empty) begin
               shreg <= fifo_dout;
               sdata <= fifo_dout[SAMPLE_W-1];
            end else begin
               shreg <= '0;
               sdata <= 1'b0;
               if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
            end
         end else if (shift_ev) begin
            // zero fill means slots past the sample naturally carry 0
            slot  <= slot + 1'b1;
            fs    <= 1'b0;
            sdata <= shreg[SAMPLE_W-2];
            shreg <= {shreg[SAMPLE_W-2:0], 1'b0};
         end
      end
   end
endmodule

// File: tb/tb_fir_dac_tx.sv
// Directed bench for fir_dac_tx (FIFO_DEPTH=4, CLK_DIV=2, FRAME_BITS=32).
module tb_fir_dac_tx;
   import fir_stream_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       in_valid = 1'b0;
   sample_t    in_sample = '0;
   logic       in_ready, sclk, fs, sdata;
   logic [2:0] fifo_level;
   logic [15:0] underrun_cnt;

   int checks = 0;
   int failures = 0;

   sample_t vec [5] = '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234};

   fir_dac_tx #(.FIFO_DEPTH(4), .CLK_DIV(2), .FRAME_BITS(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .in_valid     (in_valid),
      .in_sample    (in_sample),
      .in_ready     (in_ready),
      .sclk         (sclk),
      .fs           (fs),
      .sdata        (sdata),
      .fifo_level   (fifo_level),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Capture one frame: wait for fs, then record sdata while sclk is high
   // for each of the 32 slots. Optionally drop en after slot stop_slot.
   task automatic get_frame(input string tag, input int stop_slot,
                            output logic [31:0] bits, output logic [15:0] ur);
      int   n;
      logic fs_ok;
      bits  = '0;
      fs_ok = 1'b1;
      n = 0;
      while (fs !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      check({tag, "_fs_found"}, {31'd0, fs}, 32'd1);
      ur = underrun_cnt;
      for (int s = 0; s < 32; s++) begin
         n = 0;
         while (sclk !== 1'b1 && n < 20) begin @(negedge clk); n++; end
         bits[31-s] = sdata;
         if (fs !== (s == 0)) fs_ok = 1'b0;
         if (s == stop_slot) en = 1'b0;
         n = 0;
         while (sclk !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      end
      check({tag, "_fs_slot0_only"}, {31'd0, fs_ok}, 32'd1);
   endtask

   initial begin
      logic [31:0] bits;
      logic [15:0] ur;
      int          n;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_sclk", sclk, 0);
      check("rst_fs", fs, 0);
      check("rst_sdata", sdata, 0);
      check("rst_level", fifo_level, 0);
      check("rst_underrun", underrun_cnt, 0);
      rst = 1'b1;
      @(negedge clk);

      // 1: push while idle, enable, first load 4 cycles after RUN
      in_valid = 1'b1; in_sample = 16'hA5C3;
      @(negedge clk);
      in_valid = 1'b0;
      check("t1_level_push", fifo_level, 1);
      en = 1'b1;
      repeat (4) @(negedge clk);
      check("t1_no_early_fs", fs, 0);
      @(negedge clk);
      check("t1_fs_at_load", fs, 1);
      check("t1_sdata_msb", sdata, 1);
      check("t1_level_pop", fifo_level, 0);
      get_frame("t1", -1, bits, ur);
      check("t1_bits", bits, 32'hA5C3_0000);
      check("t1_underrun", ur, 0);

      // 2: empty frames count underruns
      for (int i = 1; i <= 4; i++) begin
         get_frame("t2", -1, bits, ur);
         check("t2_bits", bits, 32'h0);
         check("t2_underrun", ur, i);
      end

      // 3: stop, then fill the FIFO past full while idle
      en = 1'b0;
      repeat (200) @(negedge clk);
      check("t3_idle_sclk", sclk, 0);
      check("t3_idle_fs", fs, 0);
      check("t3_underrun", underrun_cnt, 5);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t3_ready_before", in_ready, 1);
         in_sample = vec[i];
         @(negedge clk);
         check("t3_level", fifo_level, i + 1);
      end
      check("t3_ready_full", in_ready, 0);
      in_sample = vec[4];
      repeat (2) @(negedge clk);
      check("t3_level_held", fifo_level, 4);
      check("t3_ready_held", in_ready, 0);
      en = 1'b1;
      repeat (5) @(negedge clk);
      check("t3_fs_load", fs, 1);
      check("t3_level_after_pop", fifo_level, 3);
      check("t3_ready_after_pop", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("t3_level_fifth", fifo_level, 4);
      check("t3_ready_fifth", in_ready, 0);

      // 4: back-to-back streaming patterns
      for (int i = 0; i < 4; i++) begin
         get_frame("t4", -1, bits, ur);
         check("t4_bits", bits, {vec[i], 16'h0});
         check("t4_underrun", ur, 5);
      end
      check("t4_level_end", fifo_level, 0);

      // 5: drop en at slot 10 of the 0x1234 frame; a queued sample must stay queued
      in_valid = 1'b1; in_sample = 16'hBEEF;
      @(negedge clk);
      in_valid = 1'b0;
      check("t5_level_push", fifo_level, 1);
      get_frame("t5", 10, bits, ur);
      check("t5_bits", bits, 32'h1234_0000);
      check("t5_end_sclk", sclk, 0);
      check("t5_end_fs", fs, 0);
      check("t5_end_sdata", sdata, 0);
      check("t5_end_level", fifo_level, 1);
      repeat (150) @(negedge clk);
      check("t5_idle_sclk", sclk, 0);
      check("t5_idle_fs", fs, 0);
      check("t5_idle_level", fifo_level, 1);
      check("t5_idle_underrun", underrun_cnt, 5);

      // 6: reset mid-frame with three samples queued
      in_valid = 1'b1; in_sample = 16'h1111;
      @(negedge clk);
      in_sample = 16'h2222;
      @(negedge clk);
      in_valid = 1'b0;
      check("t6_level3", fifo_level, 3);
      en = 1'b1;
      repeat (5) @(negedge clk);
      check("t6_fs_load", fs, 1);
      check("t6_level_pop", fifo_level, 2);
      in_valid = 1'b1; in_sample = 16'h3333;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!(sclk === 1'b1 && fs === 1'b0 && sdata === 1'b1) && n < 100) begin
         @(negedge clk); n++;
      end
      check("t6_precond_active", {31'd0, (sclk === 1'b1 && sdata === 1'b1)}, 1);
      check("t6_precond_level", fifo_level, 3);
      #2 rst = 1'b0;
      #1;
      check("t6_rst_sclk", sclk, 0);
      check("t6_rst_sdata", sdata, 0);
      check("t6_rst_fs", fs, 0);
      check("t6_rst_level", fifo_level, 0);
      check("t6_rst_ready", in_ready, 1);
      check("t6_rst_underrun", underrun_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      force dut.underrun_cnt = 16'hFFFE;
      #1;
      release dut.underrun_cnt;
      get_frame("t6a", -1, bits, ur);
      check("t6_sat_bits", bits, 32'h0);
      check("t6_sat_reach", ur, 16'hFFFF);
      get_frame("t6b", -1, bits, ur);
      check("t6_sat_hold", ur, 16'hFFFF);
      en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
